// File: rtl/int_gateway_pkg.sv
// Shared definitions for the interrupt gateway: per-source FSM encoding and
// default configuration constants.
package int_gateway_pkg;

  localparam int DEF_N_INT_SRC  = 32;
  localparam int DEF_W_SRC_ID   = 5;
  localparam int DEF_W_EDGE_CNT = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2
  } gw_state_e;

endpackage

// File: rtl/int_gateway_src.sv
// One interrupt source: line synchronizer, optional edge counter and the
// IDLE/REQ/BUSY gateway FSM. Edge counting exists only with INT_GATEWAY_EDGE_EN.
module int_gateway_src
  import int_gateway_pkg::*;
`ifdef INT_GATEWAY_EDGE_EN
#(
  parameter int   W_EDGE_CNT = DEF_W_EDGE_CNT,
  parameter logic IS_EDGE    = 1'b0
)
`endif
(
  input  logic CLK,
  input  logic RST_X,
  input  logic irq,
  input  logic claim,
  input  logic complete,
  output logic req,
  output logic inflight
);

  logic [1:0] sync_r;
  gw_state_e  state_r;
  gw_state_e  state_s;
  logic       trig_s;
  logic       req_r;
  logic       inflight_r;

  // two-flop synchronizer for the asynchronous device line
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], irq};
    end
  end

`ifdef INT_GATEWAY_EDGE_EN
  localparam logic [W_EDGE_CNT-1:0] CNT_MAX  = {W_EDGE_CNT{1'b1}};
  localparam logic [W_EDGE_CNT-1:0] CNT_ZERO = {W_EDGE_CNT{1'b0}};
  localparam logic [W_EDGE_CNT-1:0] CNT_ONE  = W_EDGE_CNT'(1);

  logic                  sync_d_r;
  logic [W_EDGE_CNT-1:0] cnt_r;
  logic                  inc_s;
  logic                  dec_s;

  // rising-edge detect, saturating increment, decrement on accepted claim
  always_comb begin
    inc_s = IS_EDGE && sync_r[1] && !sync_d_r && (cnt_r != CNT_MAX);
    dec_s = IS_EDGE && (state_r == S_REQ) && claim;
    if (IS_EDGE) begin
      trig_s = (cnt_r != CNT_ZERO);
    end else begin
      trig_s = sync_r[1];
    end
  end

  // edge history and pending-edge counter
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      sync_d_r <= 1'b0;
      cnt_r    <= CNT_ZERO;
    end else begin
      sync_d_r <= sync_r[1];
      case ({inc_s, dec_s})
        2'b10:   cnt_r <= cnt_r + CNT_ONE;
        2'b01:   cnt_r <= cnt_r - CNT_ONE;
        default: cnt_r <= cnt_r;
      endcase
    end
  end
`else
  assign trig_s = sync_r[1];
`endif

  // next-state logic; a claim only matters in REQ and a complete only in BUSY,
  // so a same-cycle claim/complete of one ID resolves to the claim
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (trig_s) state_s = S_REQ;
        else        state_s = S_IDLE;
      end
      S_REQ: begin
        if (claim) state_s = S_BUSY;
        else       state_s = S_REQ;
      end
      S_BUSY: begin
        if (complete) state_s = S_IDLE;
        else          state_s = S_BUSY;
      end
      default: state_s = S_IDLE;
    endcase
  end

  // state register with outputs registered from the next state
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state_r    <= S_IDLE;
      req_r      <= 1'b0;
      inflight_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      req_r      <= (state_s == S_REQ);
      inflight_r <= (state_s == S_BUSY);
    end
  end

  assign req      = req_r;
  assign inflight = inflight_r;

endmodule

// File: rtl/int_gateway.sv
// Interrupt gateway top: decodes claim/complete IDs and fans them out to one
// int_gateway_src per source. Edge-triggered sources need INT_GATEWAY_EDGE_EN.
module int_gateway
  import int_gateway_pkg::*;
#(
  parameter int                   N_INT_SRC  = DEF_N_INT_SRC,
  parameter int                   W_SRC_ID   = DEF_W_SRC_ID,
  parameter int                   W_EDGE_CNT = DEF_W_EDGE_CNT,
  parameter logic [N_INT_SRC-1:0] EDGE_MASK  = {N_INT_SRC{1'b0}}
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  input  logic [N_INT_SRC-1:0] w_irq,
  input  logic                 w_claim,
  input  logic [W_SRC_ID-1:0]  w_claim_id,
  input  logic                 w_complete,
  input  logic [W_SRC_ID-1:0]  w_complete_id,
  output logic [N_INT_SRC-1:0] w_req,
  output logic [N_INT_SRC-1:0] w_inflight
);

  // ID 0 is reserved and never requests
  assign w_req[0]      = 1'b0;
  assign w_inflight[0] = 1'b0;

  logic unused_s;
`ifdef INT_GATEWAY_EDGE_EN
  assign unused_s = w_irq[0];
`else
  assign unused_s = ^{EDGE_MASK, (W_EDGE_CNT > 0), w_irq[0]};
`endif

  // full-width compare, so IDs at or beyond N_INT_SRC match nothing
  for (genvar i = 1; i < N_INT_SRC; i++) begin : g_src
    logic claim_s;
    logic complete_s;

    assign claim_s    = w_claim    && (w_claim_id    == W_SRC_ID'(i));
    assign complete_s = w_complete && (w_complete_id == W_SRC_ID'(i));

    int_gateway_src
`ifdef INT_GATEWAY_EDGE_EN
    #(
      .W_EDGE_CNT (W_EDGE_CNT),
      .IS_EDGE    (EDGE_MASK[i])
    )
`endif
    u_src (
      .CLK      (CLK),
      .RST_X    (RST_X),
      .irq      (w_irq[i]),
      .claim    (claim_s),
      .complete (complete_s),
      .req      (w_req[i]),
      .inflight (w_inflight[i])
    );
  end

endmodule

// File: tb/tb_int_gateway.sv
// Self-checking bench for int_gateway: directed scenarios plus randomized
// traffic compared against a behavioural model of the gateway rules.
module tb_int_gateway;

  localparam int NS  = 32;
  localparam int WID = 6;

  logic           CLK = 1'b0;
  logic           RST_X = 1'b0;
  logic [NS-1:0]  w_irq = '0;
  logic           w_claim = 1'b0;
  logic [WID-1:0] w_claim_id = '0;
  logic           w_complete = 1'b0;
  logic [WID-1:0] w_complete_id = '0;
  logic [NS-1:0]  w_req;
  logic [NS-1:0]  w_inflight;

  int n_tests = 0;
  int n_fail  = 0;

  // model: pending/in-flight sets plus the line as seen two edges ago
  logic [NS-1:0] m_pend, m_infl, m_p1, m_p2;

  int_gateway #(
    .N_INT_SRC  (NS),
    .W_SRC_ID   (WID),
    .W_EDGE_CNT (3),
    .EDGE_MASK  (32'h0000_0020)
  ) dut (
    .CLK           (CLK),
    .RST_X         (RST_X),
    .w_irq         (w_irq),
    .w_claim       (w_claim),
    .w_claim_id    (w_claim_id),
    .w_complete    (w_complete),
    .w_complete_id (w_complete_id),
    .w_req         (w_req),
    .w_inflight    (w_inflight)
  );

  always #5 CLK = ~CLK;

  task automatic model_reset();
    m_pend = '0;
    m_infl = '0;
    m_p1   = '0;
    m_p2   = '0;
  endtask

  task automatic model_step();
    if (!RST_X) begin
      model_reset();
    end else begin
      for (int i = 1; i < NS; i++) begin
        if (m_pend[i]) begin
          if (w_claim && (32'(w_claim_id) == i)) begin
            m_pend[i] = 1'b0;
            m_infl[i] = 1'b1;
          end
        end else if (m_infl[i]) begin
          if (w_complete && (32'(w_complete_id) == i)) m_infl[i] = 1'b0;
        end else if (m_p2[i]) begin
          m_pend[i] = 1'b1;
        end
      end
      m_p2 = m_p1;
      m_p1 = w_irq;
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_X = 1'b0;
    w_irq = '0; w_claim = 1'b0; w_complete = 1'b0;
    model_reset();
    tick(); tick();
    RST_X = 1'b1;
  endtask

  task automatic test_reset();
    RST_X = 1'b0;
    w_irq = '1;
    model_reset();
    tick(); tick(); tick();
    n_tests++; if (w_req !== '0) begin n_fail++; $display("FAIL reset_req: got %h want 0", w_req); end
    n_tests++; if (w_inflight !== '0) begin n_fail++; $display("FAIL reset_infl: got %h want 0", w_inflight); end
    w_irq = '0;
    RST_X = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (w_req !== '0) begin n_fail++; $display("FAIL post_reset_req: got %h want 0", w_req); end
    n_tests++; if (w_inflight !== '0) begin n_fail++; $display("FAIL post_reset_infl: got %h want 0", w_inflight); end
  endtask

  task automatic test_basic();
    w_irq[3] = 1'b1;
    tick(); tick();
    n_tests++; if (w_req[3] !== 1'b0) begin n_fail++; $display("FAIL req3_cycle2: got %b want 0", w_req[3]); end
    tick();
    n_tests++; if (w_req[3] !== 1'b1) begin n_fail++; $display("FAIL req3_cycle3: got %b want 1", w_req[3]); end
    tick(); tick();
    w_claim = 1'b1; w_claim_id = 6'd3;
    tick();
    w_claim = 1'b0;
    n_tests++; if (w_req[3] !== 1'b0) begin n_fail++; $display("FAIL claim3_req: got %b want 0", w_req[3]); end
    n_tests++; if (w_inflight[3] !== 1'b1) begin n_fail++; $display("FAIL claim3_infl: got %b want 1", w_inflight[3]); end
    n_tests++; if (w_req !== m_pend) begin n_fail++; $display("FAIL basic_vec: got %h want %h", w_req, m_pend); end
  endtask

  task automatic test_rearm();
    w_complete = 1'b1; w_complete_id = 6'd3;
    tick();
    w_complete = 1'b0;
    n_tests++; if (w_inflight[3] !== 1'b0) begin n_fail++; $display("FAIL rearm_infl: got %b want 0", w_inflight[3]); end
    n_tests++; if (w_req[3] !== 1'b0) begin n_fail++; $display("FAIL rearm_req_early: got %b want 0", w_req[3]); end
    tick();
    n_tests++; if (w_req[3] !== 1'b1) begin n_fail++; $display("FAIL rearm_req: got %b want 1", w_req[3]); end
  endtask

  task automatic test_ignore();
    w_claim = 1'b1; w_claim_id = 6'd7;
    tick();
    w_claim = 1'b0;
    n_tests++; if (w_req !== m_pend) begin n_fail++; $display("FAIL ign_claim7_req: got %h want %h", w_req, m_pend); end
    n_tests++; if (w_inflight !== m_infl) begin n_fail++; $display("FAIL ign_claim7_infl: got %h want %h", w_inflight, m_infl); end
    w_complete = 1'b1; w_complete_id = 6'd7;
    tick();
    w_complete = 1'b0;
    n_tests++; if (w_inflight[7] !== 1'b0 || w_req[7] !== 1'b0) begin n_fail++; $display("FAIL ign_cpl7: got req=%b infl=%b want 0 0", w_req[7], w_inflight[7]); end
    n_tests++; if (w_inflight !== m_infl) begin n_fail++; $display("FAIL ign_cpl7_vec: got %h want %h", w_inflight, m_infl); end
    // ID 35 aliases source 3 in the low five bits; it must not claim it
    w_claim = 1'b1; w_claim_id = 6'd35;
    tick();
    w_claim = 1'b0;
    n_tests++; if (w_req[3] !== 1'b1 || w_inflight[3] !== 1'b0) begin n_fail++; $display("FAIL ign_id35: got req=%b infl=%b want 1 0", w_req[3], w_inflight[3]); end
    n_tests++; if (w_req !== m_pend) begin n_fail++; $display("FAIL ign_id35_vec: got %h want %h", w_req, m_pend); end
  endtask

  task automatic test_simul();
    w_irq[2] = 1'b1; w_irq[4] = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (w_req[2] !== 1'b1 || w_req[4] !== 1'b1) begin n_fail++; $display("FAIL sim_req24: got %b%b want 11", w_req[2], w_req[4]); end
    w_claim = 1'b1; w_claim_id = 6'd4;
    tick();
    w_claim = 1'b1; w_claim_id = 6'd2; w_complete = 1'b1; w_complete_id = 6'd4;
    tick();
    w_claim = 1'b0; w_complete = 1'b0;
    n_tests++; if (w_inflight[2] !== 1'b1 || w_req[2] !== 1'b0) begin n_fail++; $display("FAIL sim_claim2: got req=%b infl=%b want 0 1", w_req[2], w_inflight[2]); end
    n_tests++; if (w_inflight[4] !== 1'b0 || w_req[4] !== 1'b0) begin n_fail++; $display("FAIL sim_cpl4: got req=%b infl=%b want 0 0", w_req[4], w_inflight[4]); end
    tick();
    n_tests++; if (w_req[4] !== 1'b1) begin n_fail++; $display("FAIL sim_rereq4: got %b want 1", w_req[4]); end
    w_complete = 1'b1; w_complete_id = 6'd2;
    tick();
    w_complete = 1'b0;
    tick();
    n_tests++; if (w_req[2] !== 1'b1) begin n_fail++; $display("FAIL sim_rereq2: got %b want 1", w_req[2]); end
    w_claim = 1'b1; w_claim_id = 6'd2; w_complete = 1'b1; w_complete_id = 6'd2;
    tick();
    w_claim = 1'b0; w_complete = 1'b0;
    n_tests++; if (w_inflight[2] !== 1'b1 || w_req[2] !== 1'b0) begin n_fail++; $display("FAIL same_id_claim: got req=%b infl=%b want 0 1", w_req[2], w_inflight[2]); end
    tick();
    n_tests++; if (w_inflight[2] !== 1'b1) begin n_fail++; $display("FAIL same_id_hold: got %b want 1", w_inflight[2]); end
    n_tests++; if (w_inflight !== m_infl) begin n_fail++; $display("FAIL sim_vec: got %h want %h", w_inflight, m_infl); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) w_irq = $urandom & 32'hFFFF_FFDF;
      w_claim       = ($urandom_range(0, 1) == 1);
      w_claim_id    = WID'($urandom_range(0, 39));
      w_complete    = ($urandom_range(0, 1) == 1);
      w_complete_id = WID'($urandom_range(0, 39));
      tick();
      n_tests++; if (w_req !== m_pend) begin n_fail++; $display("FAIL rnd_req c=%0d: got %h want %h", c, w_req, m_pend); end
      n_tests++; if (w_inflight !== m_infl) begin n_fail++; $display("FAIL rnd_infl c=%0d: got %h want %h", c, w_inflight, m_infl); end
    end
    w_claim = 1'b0; w_complete = 1'b0; w_irq = '0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    w_irq[3] = 1'b1;
    tick(); tick(); tick();
    w_claim = 1'b1; w_claim_id = 6'd3;
    tick();
    w_claim = 1'b0;
    n_tests++; if (w_inflight[3] !== 1'b1) begin n_fail++; $display("FAIL mid_busy3: got %b want 1", w_inflight[3]); end
    #2;
    RST_X = 1'b0;
    #1;
    n_tests++; if (w_req !== '0) begin n_fail++; $display("FAIL async_req: got %h want 0", w_req); end
    n_tests++; if (w_inflight !== '0) begin n_fail++; $display("FAIL async_infl: got %h want 0", w_inflight); end
    model_reset();
    w_irq = '0;
    tick(); tick();
    RST_X = 1'b1;
    tick();
    w_complete = 1'b1; w_complete_id = 6'd3;
    tick();
    w_complete = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (w_inflight !== '0) begin n_fail++; $display("FAIL stale_cpl_infl: got %h want 0", w_inflight); end
    n_tests++; if (w_req !== '0) begin n_fail++; $display("FAIL stale_cpl_req: got %h want 0", w_req); end
  endtask

  task automatic test_edge();
    int rounds;
    int waited;
    int exp_rounds;
`ifdef INT_GATEWAY_EDGE_EN
    exp_rounds = 7;
`else
    exp_rounds = 1;
`endif
    do_reset();
    for (int p = 0; p < 9; p++) begin
      w_irq[5] = 1'b1; tick(); tick();
      w_irq[5] = 1'b0; tick(); tick();
    end
    tick(); tick(); tick();
    n_tests++; if (w_req[5] !== 1'b1) begin n_fail++; $display("FAIL edge_req5: got %b want 1", w_req[5]); end
    rounds = 0;
    for (int r = 0; r < 10; r++) begin
      waited = 0;
      while (w_req[5] !== 1'b1 && waited < 6) begin tick(); waited++; end
      if (w_req[5] !== 1'b1) break;
      w_claim = 1'b1; w_claim_id = 6'd5; tick(); w_claim = 1'b0;
      w_complete = 1'b1; w_complete_id = 6'd5; tick(); w_complete = 1'b0;
      rounds++;
    end
    n_tests++; if (rounds != exp_rounds) begin n_fail++; $display("FAIL edge_rounds: got %0d want %0d", rounds, exp_rounds); end
    n_tests++; if (w_req[5] !== 1'b0 || w_inflight[5] !== 1'b0) begin n_fail++; $display("FAIL edge_drained: got req=%b infl=%b want 0 0", w_req[5], w_inflight[5]); end
  endtask

  initial begin
    model_reset();
    @(negedge CLK);
    test_reset();
    test_basic();
    test_rearm();
    test_ignore();
    test_simul();
    test_random();
    test_reset_mid();
    test_edge();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/int_gateway.md
INT_GATEWAY -- requirements
Module: int_gateway

Interface
REQ-001 SHALL have parameter N_INT_SRC, default 32: number of interrupt source IDs, including reserved ID 0.
REQ-002 SHALL have parameter W_SRC_ID, default 5: width of a source ID; 2^W_SRC_ID SHALL be at least N_INT_SRC.
REQ-003 SHALL have parameter W_EDGE_CNT, default 3: width of the per-source edge counter.
REQ-004 SHALL have parameter EDGE_MASK, width N_INT_SRC, default 0: bit i=1 makes source i edge-triggered.
REQ-005 SHALL have port CLK, input, 1 bit: the single clock.
REQ-006 SHALL have port RST_X, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port w_irq, input, N_INT_SRC bits: raw device interrupt lines, asynchronous to CLK.
REQ-008 SHALL have port w_claim, input, 1 bit: one-cycle pulse meaning the PLIC claimed w_claim_id.
REQ-009 SHALL have port w_claim_id, input, W_SRC_ID bits: ID being claimed.
REQ-010 SHALL have port w_complete, input, 1 bit: one-cycle pulse meaning the hart completed w_complete_id.
REQ-011 SHALL have port w_complete_id, input, W_SRC_ID bits: ID being completed.
REQ-012 SHALL have port w_req, output, N_INT_SRC bits: registered request to the PLIC pending bits.
REQ-013 SHALL have port w_inflight, output, N_INT_SRC bits: registered flag, source claimed and awaiting completion.

Function
REQ-014 SHALL pass each w_irq bit through a 2-flop synchronizer before any use.
REQ-015 SHALL give each source i≥1 a 3-state FSM: IDLE (req=0, inflight=0), REQ (req=1, inflight=0), BUSY (req=0, inflight=1).
REQ-016 SHALL hold ID 0 permanently in IDLE, with w_req[0]=0 and w_inflight[0]=0.
REQ-017 Level source, IDLE->REQ: synchronized line is 1; w_req SHALL rise 3 cycles after a stable raw high.
REQ-018 REQ->BUSY: SHALL occur on w_claim with w_claim_id==i; w_req[i] SHALL fall the following cycle.
REQ-019 BUSY->IDLE: SHALL occur on w_complete with w_complete_id==i; a level source still high SHALL re-enter REQ one cycle later.
REQ-020 SHALL ignore a claim for a source not in REQ, and a complete for a source not in BUSY (no state change).
REQ-021 SHALL ignore IDs ≥ N_INT_SRC.
REQ-022 SHALL process a claim and a complete in the same cycle independently when the IDs differ.
REQ-023 Same ID, same cycle: the claim SHALL be acted on and the complete ignored.
REQ-024 SHALL keep a level source in REQ if its line drops while in REQ; no withdrawal.

Reset
REQ-025 While RST_X=0: all FSMs SHALL be in IDLE, synchronizers and edge counters 0, and w_req=0, w_inflight=0.
REQ-026 SHALL clear in-flight state on reset mid-operation; later completes for those IDs are ignored per REQ-020.

Configuration
REQ-027 With macro INT_GATEWAY_EDGE_EN defined, sources with EDGE_MASK bit set SHALL be edge-triggered as follows.
- A synchronized 0->1 transition increments the source counter.
- The counter saturates at 2^W_EDGE_CNT-1; further edges are dropped.
- IDLE->REQ occurs when counter>0.
- The counter decrements on that source's accepted claim.
- An increment and a decrement in the same cycle leave the counter unchanged.
REQ-028 Without INT_GATEWAY_EDGE_EN, EDGE_MASK SHALL be ignored, all sources SHALL be level-triggered, and no counter or edge logic SHALL exist.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, REQ=2'd1, BUSY=2'd2) and the default parameter constants.
REQ-030 SHALL contain one sub-module, int_gateway_src, instantiated per source and holding the synchronizer, counter and FSM.
REQ-031 The top level SHALL only decode the claim and complete IDs.

Verification
REQ-032 Test: w_irq[3] held high from cycle 0 -> w_req[3]=1 at cycle 3; claim id 3 at cycle 5 -> w_req[3]=0 and w_inflight[3]=1 at cycle 6.
REQ-033 Test: level source 3 in BUSY with line still high, complete id 3 -> w_inflight[3]=0 next cycle, then w_req[3]=1 the cycle after.
REQ-034 Test: claim id 7 while source 7 is IDLE, and complete id 7 while it is IDLE -> no change on any output.
REQ-035 Test: same-cycle claim id 2 (in REQ) and complete id 4 (in BUSY) -> both transitions occur; same-cycle claim and complete of id 2 -> only the claim takes effect.
REQ-036 Test (EDGE_EN, EDGE_MASK[5]=1): 9 pulses on w_irq[5] -> counter saturates at 7; exactly 7 claim/complete rounds are serviced, then w_req[5] stays 0.
REQ-037 Test: assert RST_X=0 with source 3 in BUSY -> w_req=0 and w_inflight=0 immediately (asynchronous); a following complete id 3 is ignored.
